// File: rtl/ma_lsu.sv
// ma_lsu: single-outstanding RV32 load/store unit. Byte and half stores use
// read-modify-write on a word-addressed data memory that has a combinational read.
module ma_lsu #(
    parameter int IDX_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_write,
    output logic [1:0]  mem_read,
    input  logic [31:0] mem_data_out
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
    state_t state, state_nx;
    logic [IDX_W+1:0] addr_q;
    logic [2:0] funct3_q;
    logic [31:0] wdata_q, rdata_q, load_val, lane_mask, merged;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [4:0] shamt;
    logic err_q, illegal, misaligned, out_of_range, err;

    always_comb begin
        illegal = req_store ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
        misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
        out_of_range = req_addr[31:IDX_W+2] != '0;
        err = illegal | misaligned | out_of_range;
    end

    // Lane extraction for loads and lane merge for byte/half stores.
    always_comb begin
        shamt = {addr_q[1:0], 3'b000};
        lane_b = mem_data_out[shamt +: 8];
        lane_h = mem_data_out[{addr_q[1], 4'b0000} +: 16];
        load_val = funct3_q == 3'd0 ? {{24{lane_b[7]}}, lane_b} :
                   funct3_q == 3'd1 ? {{16{lane_h[15]}}, lane_h} :
                   funct3_q == 3'd4 ? {24'd0, lane_b} :
                   funct3_q == 3'd5 ? {16'd0, lane_h} : mem_data_out;
        lane_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
        merged = (mem_data_out & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mem_read = 2'b00;
        mem_write = 2'b00;
        case (state)
            IDLE:
                if (req_valid)
                    state_nx = err ? RESP : !req_store ? LOAD :
                               req_funct3[1:0] == 2'd2 ? WRITE : RMW_RD;
            LOAD: begin
                mem_read = 2'b01;
                state_nx = RESP;
            end
            RMW_RD: begin
                mem_read = 2'b01;
                state_nx = WRITE;
            end
            WRITE: begin
                mem_write = 2'b01;
                state_nx = RESP;
            end
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // wdata_q doubles as the merged write word for byte/half stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            funct3_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (req_valid) begin
                        addr_q <= req_addr[IDX_W+1:0];
                        funct3_q <= req_funct3;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q <= err;
                    end
                LOAD: rdata_q <= load_val;
                RMW_RD: wdata_q <= merged;
                default: ;
            endcase
        end
    end

    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;
    assign resp_err = resp_valid & err_q;
    assign resp_data = resp_valid ? rdata_q : '0;
    assign mem_address = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
    assign mem_data_in = wdata_q;
endmodule

// File: tb/tb_ma_lsu.sv
// tb_ma_lsu: directed and randomized checks of ma_lsu against a byte-level
// reference model of the data memory and the load/store rules.
module tb_ma_lsu;
    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_store = 1'b0;
    logic [2:0] req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] resp_data, mem_address, mem_data_in, mem_data_out;
    logic [1:0] mem_write, mem_read;
    logic [31:0] mem [0:1023];
    logic [31:0] model [0:1023];
    int checks = 0, passed = 0;

    typedef struct packed {
        logic err;
        logic [31:0] data;
        logic [3:0] lat, nrd, nwr;
        logic both;
        logic [31:0] waddr, wword;
    } res_t;

    ma_lsu #(.IDX_W(10)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    assign mem_data_out = mem[mem_address[9:0]];
    always @(posedge clk) if (mem_write == 2'b01) mem[mem_address[9:0]] <= mem_data_in;

    // Reference: expected response from the op's rules; stores update the model memory.
    function automatic res_t predict(input logic st, input logic [2:0] f,
                                     input logic [31:0] a, input logic [31:0] wd);
        res_t e = '0;
        int size = 1 << f[1:0];
        int off = int'(a[1:0]);
        logic [31:0] w = model[a[11:2]];
        logic [31:0] v;
        logic bad = (a >= 32'd4096) || (st ? f > 3'd2 : (f == 3'd3 || f == 3'd6 || f == 3'd7)) ||
                    (off % size != 0);
        if (bad) begin
            e.err = 1'b1;
            e.lat = 4'd1;
            return e;
        end
        if (!st) begin
            v = w >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            e.data = v;
            e.lat = 4'd2;
            e.nrd = 4'd1;
        end else begin
            for (int b = 0; b < size; b++) begin
                int p;
                p = 8 * (off + b);
                w = (w & ~(32'hFF << p)) | (((wd >> (8 * b)) & 32'hFF) << p);
            end
            e.lat = size == 4 ? 4'd2 : 4'd3;
            e.nrd = size == 4 ? 4'd0 : 4'd1;
            e.nwr = 4'd1;
            e.waddr = a >> 2;
            e.wword = w;
            model[a[11:2]] = w;
        end
        return e;
    endfunction

    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, output res_t r);
        res_t o = '0;
        o.lat = 4'hF;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_read == 2'b01) o.nrd = o.nrd + 4'd1;
            if (mem_write == 2'b01) begin
                o.nwr = o.nwr + 4'd1;
                o.waddr = mem_address;
                o.wword = mem_data_in;
            end
            if (mem_read == 2'b01 && mem_write == 2'b01) o.both = 1'b1;
            if (resp_valid) begin
                o.lat = 4'(i);
                o.err = resp_err;
                o.data = resp_data;
                break;
            end
        end
        r = o;
    endtask

    task automatic test_reset;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write, resp_data, mem_address, mem_data_in}
            !== {1'b1, 102'd0})
            $display("FAIL reset_outputs got ready=%b rv=%b err=%b rd=%b wr=%b data=%h addr=%h din=%h",
                     req_ready, resp_valid, resp_err, mem_read, mem_write, resp_data, mem_address, mem_data_in);
        else passed++;
        req_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0] f [3] = '{3'd0, 3'd4, 3'd1};
        logic [31:0] want [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF};
        res_t r, e;
        mem[5] = 32'h80FF_1234; model[5] = 32'h80FF_1234;
        for (int k = 0; k < 3; k++) begin
            e = predict(1'b0, f[k], 32'h16, 32'h0);
            issue(1'b0, f[k], 32'h16, 32'h0, r);
            checks++;
            if (r !== e) $display("FAIL load_model f3=%0d got %h want %h", f[k], r, e);
            else passed++;
            checks++;
            if ({r.data, r.lat, r.nrd} !== {want[k], 4'd2, 4'd1})
                $display("FAIL load_const f3=%0d got data=%h lat=%0d rd=%0d want %h/2/1",
                         f[k], r.data, r.lat, r.nrd, want[k]);
            else passed++;
        end
    endtask

    task automatic test_store_word;
        res_t r, e;
        e = predict(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF);
        issue(1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, r);
        checks++;
        if (r !== e) $display("FAIL sw_model got %h want %h", r, e);
        else passed++;
        checks++;
        if ({r.nwr, r.nrd, r.waddr, r.wword, r.err, mem[8]} !== {4'd1, 4'd0, 32'd8, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF})
            $display("FAIL sw_const got wr=%0d rd=%0d addr=%h din=%h err=%b mem=%h",
                     r.nwr, r.nrd, r.waddr, r.wword, r.err, mem[8]);
        else passed++;
    endtask

    task automatic test_rmw;
        logic [2:0] f [2] = '{3'd0, 3'd1};
        logic [31:0] a [2] = '{32'h21, 32'h22};
        logic [31:0] wd [2] = '{32'h0000_00AA, 32'h0000_5566};
        logic [31:0] want [2] = '{32'h1122_AA44, 32'h5566_3344};
        res_t r, e;
        for (int k = 0; k < 2; k++) begin
            mem[8] = 32'h1122_3344; model[8] = 32'h1122_3344;
            e = predict(1'b1, f[k], a[k], wd[k]);
            issue(1'b1, f[k], a[k], wd[k], r);
            checks++;
            if (r !== e) $display("FAIL rmw_model f3=%0d got %h want %h", f[k], r, e);
            else passed++;
            checks++;
            if ({r.lat, r.nrd, r.nwr, r.wword, mem[8]} !== {4'd3, 4'd1, 4'd1, want[k], want[k]})
                $display("FAIL rmw_const f3=%0d got lat=%0d rd=%0d wr=%0d din=%h mem=%h want %h",
                         f[k], r.lat, r.nrd, r.nwr, r.wword, mem[8], want[k]);
            else passed++;
        end
    endtask

    task automatic test_errors;
        logic st [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0] f [4] = '{3'd2, 3'd1, 3'd3, 3'd2};
        logic [31:0] a [4] = '{32'h2, 32'h3, 32'h10, 32'h1000};
        res_t r, e;
        e = '0;
        e.err = 1'b1;
        e.lat = 4'd1;
        for (int k = 0; k < 4; k++) begin
            issue(st[k], f[k], a[k], 32'hFFFF_FFFF, r);
            checks++;
            if (r !== e) $display("FAIL error_case%0d got %h want %h", k, r, e);
            else passed++;
        end
    endtask

    task automatic test_random;
        res_t r, e;
        logic st;
        logic [2:0] f;
        logic [31:0] a, wd;
        for (int k = 0; k < 60; k++) begin
            st = 1'($urandom);
            f = 3'($urandom);
            wd = $urandom;
            a = ($urandom_range(0, 9) == 0) ? $urandom : {20'd0, 12'($urandom)};
            e = predict(st, f, a, wd);
            issue(st, f, a, wd, r);
            checks++;
            if (r !== e) $display("FAIL random%0d st=%b f3=%0d a=%h got %h want %h", k, st, f, a, r, e);
            else passed++;
            checks++;
            if (mem[a[11:2]] !== model[a[11:2]])
                $display("FAIL random_mem%0d got %h want %h", k, mem[a[11:2]], model[a[11:2]]);
            else passed++;
        end
    endtask

    task automatic test_reset_abort;
        res_t r, e;
        logic seen = 1'b0;
        mem[8] = 32'h1122_3344; model[8] = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_write !== 2'b01) $display("FAIL abort_in_write got wr=%b want 01", mem_write);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write, resp_data, mem_address, mem_data_in}
            !== {1'b1, 102'd0})
            $display("FAIL abort_outputs got ready=%b rv=%b wr=%b addr=%h din=%h",
                     req_ready, resp_valid, mem_write, mem_address, mem_data_in);
        else passed++;
        repeat (2) @(negedge clk) seen = seen | resp_valid | (mem_write != 2'b00);
        reset = 1'b1;
        repeat (3) @(negedge clk) seen = seen | resp_valid | (mem_write != 2'b00);
        checks++;
        if ({seen, mem[8]} !== {1'b0, 32'h1122_3344})
            $display("FAIL abort_no_effect got seen=%b mem=%h want 0/11223344", seen, mem[8]);
        else passed++;
        e = predict(1'b0, 3'd2, 32'h20, 32'h0);
        issue(1'b0, 3'd2, 32'h20, 32'h0, r);
        checks++;
        if ({r, r.lat, r.data} !== {e, 4'd2, 32'h1122_3344})
            $display("FAIL abort_then_lw got %h want %h", r, e);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d [3];
        int acc [3] = '{0, 0, 0};
        int n = 0, writes = 0, overlap = 0;
        logic pr;
        for (int k = 0; k < 3; k++) begin
            d[k] = $urandom;
            void'(predict(1'b1, 3'd2, 32'h40 + 4 * k, d[k]));
        end
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = d[0];
        pr = req_ready;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (mem_write == 2'b01) writes++;
            if (req_ready && (mem_write != 2'b00 || resp_valid)) overlap++;
            if (pr && !req_ready && n < 3) begin
                acc[n] = i;
                n++;
                if (n < 3) begin
                    req_addr = 32'h40 + 4 * n;
                    req_wdata = d[n];
                end else req_valid = 1'b0;
            end
            pr = req_ready;
        end
        req_valid = 1'b0;
        checks++;
        if ({n, acc[1] - acc[0], acc[2] - acc[1]} !== {32'd3, 32'd3, 32'd3})
            $display("FAIL b2b_spacing got n=%0d gaps=%0d,%0d want 3/3,3", n, acc[1] - acc[0], acc[2] - acc[1]);
        else passed++;
        checks++;
        if ({writes, overlap} !== {32'd3, 32'd0})
            $display("FAIL b2b_writes got writes=%0d ready_overlap=%0d want 3/0", writes, overlap);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem[16 + k] !== model[16 + k])
                $display("FAIL b2b_mem%0d got %h want %h", k, mem[16 + k], model[16 + k]);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            model[i] = mem[i];
        end
        test_reset;
        test_loads;
        test_store_word;
        test_rmw;
        test_errors;
        test_random;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
